input_conditioner: RTL

- Parametrised successor to the plain two-flop input synchroniser.
- Takes WIDTH asynchronous external lines, for example sniffed SPI/UART/I2C lines on the MITM bridge, into the sys_clk domain.
- Per channel it provides:
  - a configurable-depth synchroniser chain;
  - a glitch filter, so the output changes only after the input has been stable for FILTER_LEN cycles;
  - one-cycle rise/fall strobes.
- Sits directly behind the pins and feeds every protocol front-end.

---
 rtl/input_filter_channel.sv | 89 ++++++++
 rtl/input_conditioner.sv | 50 +++++
 2 files changed

// File: rtl/input_filter_channel.sv
`default_nettype none
// ============================================================================
//  Module      : input_filter_channel
//  Description : One channel of the input conditioner. It has three parts:
//                - a flop-only synchroniser chain;
//                - a stability filter, so the output follows only after
//                  FILTER_LEN consecutive differing samples;
//                - registered one-cycle rise and fall strobes that line up
//                  with the first cycle of the new output level.
//  Ports       : sys_clk   - system clock
//                sys_rst   - synchronous active-high reset
//                in_bit_i  - asynchronous raw input bit
//                out_bit_o - synchronised, filtered level
//                rise_o    - one-cycle strobe, out_bit_o went 0->1
//                fall_o    - one-cycle strobe, out_bit_o went 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module input_filter_channel #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 1,
    parameter logic IDLE_BIT    = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic in_bit_i,
    output logic out_bit_o,
    output logic rise_o,
    output logic fall_o
);

    // The counter needs at least one bit, even when FILTER_LEN == 1.
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   synced;
    logic                   update;

    assign synced = sync_q[SYNC_STAGES-1];

    // The output takes the new level on the FILTER_LEN-th consecutive
    // differing sample. Any sample that agrees with the output restarts
    // the count, which is how short glitches are rejected.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        update = 1'b0;
        if (synced == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            update = 1'b1;
            out_d  = synced;
            cnt_d  = '0;
            rise_d = synced;
            fall_d = ~synced;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= {SYNC_STAGES{IDLE_BIT}};
            cnt_q  <= '0;
            out_q  <= IDLE_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            // Keep this a pure shift register: no logic between the stages.
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit_i};
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out_bit_o = out_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Brings WIDTH asynchronous lines into the sys_clk domain.
//                Each channel has its own synchroniser, glitch filter and
//                edge strobes. The channels are fully independent.
//  Ports       : sys_clk  - system clock
//                sys_rst  - synchronous active-high reset
//                in_line  - [WIDTH] asynchronous raw inputs
//                out_line - [WIDTH] synchronised, filtered levels
//                rise     - [WIDTH] one-cycle 0->1 strobes
//                fall     - [WIDTH] one-cycle 1->0 strobes
//                any_edge - OR of every rise and fall strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTER_LEN  = 1,
    parameter logic [WIDTH-1:0] IDLE_VAL    = {WIDTH{1'b0}}
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] in_line,
    output logic [WIDTH-1:0] out_line,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        input_filter_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .IDLE_BIT    (IDLE_VAL[gi])
        ) u_chan (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .in_bit_i  (in_line[gi]),
            .out_bit_o (out_line[gi]),
            .rise_o    (rise[gi]),
            .fall_o    (fall[gi])
        );
    end

    // The strobes are already registered, so this OR adds no extra flop stage.
    assign any_edge = |(rise | fall);

endmodule
`default_nettype wire
